// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol encoding, symbol lengths in time units,
// and the playback state machine encoding.
package morse_pkg;

    localparam logic [1:0] SYM_EMPTY = 2'b00;
    localparam logic [1:0] SYM_DOT   = 2'b01;
    localparam logic [1:0] SYM_LINE  = 2'b11;

    localparam int LINE_UNITS = 3;
    localparam int GAP_UNITS  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_MARK,
        ST_GAP,
        ST_DONE
    } state_e;

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter; expire is high on the last cycle of a loaded interval,
// so an interval of N cycles is obtained by loading N.
module morse_unit_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/morse_encoder.sv
// Plays a packed Morse code (2 bits per symbol, oldest symbol in the highest
// non-empty pair) as timed marks and gaps on morse_out.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 12500000,
    parameter int CODE_W      = 10
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic [CODE_W-1:0] code,
    output logic              morse_out,
    output logic              busy,
    output logic              done
);

    localparam int PAIRS   = CODE_W / 2;
    localparam int PAIRS_W = $clog2(PAIRS + 1);
    localparam int TIMER_W = $clog2(LINE_UNITS * UNIT_CYCLES + 1);

    localparam logic [TIMER_W-1:0] DOT_COUNT  = TIMER_W'(UNIT_CYCLES);
    localparam logic [TIMER_W-1:0] LINE_COUNT = TIMER_W'(LINE_UNITS * UNIT_CYCLES);
    localparam logic [TIMER_W-1:0] GAP_COUNT  = TIMER_W'(GAP_UNITS * UNIT_CYCLES);

    state_e             state, state_next;
    logic [CODE_W-1:0]  shift_reg, shift_next;
    logic [PAIRS_W-1:0] pairs_left, pairs_next;
    logic               played, played_next;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_expire;
    logic [1:0]         top_pair;

    assign top_pair = shift_reg[CODE_W-1 -: 2];

    morse_unit_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clock  (clock),
        .resetn (resetn),
        .load   (timer_load),
        .value  (timer_value),
        .expire (timer_expire)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            pairs_left <= '0;
            played     <= 1'b0;
        end else begin
            state      <= state_next;
            shift_reg  <= shift_next;
            pairs_left <= pairs_next;
            played     <= played_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        shift_next  = shift_reg;
        pairs_next  = pairs_left;
        played_next = played;
        timer_load  = 1'b0;
        timer_value = DOT_COUNT;

        if (stop) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next  = ST_SCAN;
                        shift_next  = code;
                        pairs_next  = PAIRS_W'(PAIRS);
                        played_next = 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (pairs_left == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        case (top_pair)
                            SYM_DOT, SYM_LINE: begin
                                shift_next  = shift_reg << 2;
                                pairs_next  = pairs_left - PAIRS_W'(1);
                                played_next = 1'b1;
                                timer_load  = 1'b1;
                                timer_value = (top_pair == SYM_LINE) ? LINE_COUNT : DOT_COUNT;
                                state_next  = ST_MARK;
                            end
                            SYM_EMPTY: begin
                                // An all-empty code finishes on its last pair instead of
                                // spending one more SCAN cycle on pairs_left==0.
                                if (played || pairs_left == PAIRS_W'(1)) begin
                                    state_next = ST_DONE;
                                end else begin
                                    shift_next = shift_reg << 2;
                                    pairs_next = pairs_left - PAIRS_W'(1);
                                end
                            end
                            default: state_next = ST_DONE;
                        endcase
                    end
                end
                ST_MARK: begin
                    if (timer_expire) begin
                        timer_load  = 1'b1;
                        timer_value = GAP_COUNT;
                        state_next  = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (timer_expire) begin
                        state_next = ST_SCAN;
                    end
                end
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign morse_out = (state == ST_MARK);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_morse_encoder.sv
// Scoreboard bench for morse_encoder with UNIT_CYCLES=4: expected output events
// (busy edges, completed marks, done pulses) are queued per request and checked by a monitor.
module tb_morse_encoder;

    typedef enum int {EV_RISE, EV_MARK, EV_DONE, EV_FALL} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       a;
        int       b;
    } ev_t;

    logic       clock;
    logic       resetn;
    logic       start;
    logic       stop;
    logic [9:0] code;
    logic       morse_out;
    logic       busy;
    logic       done;

    int  cyc = 0;
    int  base = 0;
    int  total = 0;
    int  bad = 0;
    ev_t exp_q[$];

    morse_encoder #(
        .UNIT_CYCLES (4),
        .CODE_W      (10)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .stop      (stop),
        .code      (code),
        .morse_out (morse_out),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc <= cyc + 1;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic push(input ev_kind_e k, input int a, input int b);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic emit(input ev_kind_e k, input int a, input int b);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got %s a=%0d b=%0d, expected no event", k.name(), a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a != a || e.b != b) begin
                bad++;
                $display("FAIL event: got %s a=%0d b=%0d, expected %s a=%0d b=%0d",
                         k.name(), a, b, e.kind.name(), e.a, e.b);
            end
        end
    endtask

    // Monitor: cycle numbers are relative to the cycle in which start was high.
    initial begin
        logic prev_morse = 1'b0;
        logic prev_busy  = 1'b0;
        int   run_start  = 0;
        int   run_len    = 0;
        forever begin
            @(negedge clock);
            if (morse_out && !prev_morse) begin
                run_start = cyc - base;
                run_len   = 1;
            end else if (morse_out) begin
                run_len++;
            end
            if (!morse_out && prev_morse) emit(EV_MARK, run_start, run_len);
            if (done)                     emit(EV_DONE, cyc - base, 0);
            if (busy && !prev_busy)       emit(EV_RISE, cyc - base, 0);
            if (!busy && prev_busy)       emit(EV_FALL, cyc - base, 0);
            prev_morse = morse_out;
            prev_busy  = busy;
        end
    end

    task automatic pulse(input logic [9:0] c);
        @(negedge clock);
        code  = c;
        start = 1'b1;
        base  = cyc;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_rel(input int n);
        while (cyc - base < n) @(negedge clock);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        check({tag, "_pending_events"}, exp_q.size(), 0);
        check({tag, "_busy_after"}, int'(busy), 0);
        exp_q.delete();
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        code   = '0;
        repeat (3) @(negedge clock);
        check("reset_morse_out", int'(morse_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        resetn = 1'b1;
        @(negedge clock);

        // dot then line after three padding pairs
        push(EV_RISE, 1, 0); push(EV_MARK, 5, 4); push(EV_MARK, 14, 12);
        push(EV_DONE, 31, 0); push(EV_FALL, 32, 0);
        pulse(10'b00_00_00_01_11);
        drain("dot_line", 100);

        // all-empty code
        push(EV_RISE, 1, 0); push(EV_DONE, 6, 0); push(EV_FALL, 7, 0);
        pulse(10'b00_00_00_00_00);
        drain("zero", 40);

        // five dots
        push(EV_RISE, 1, 0);
        for (int i = 0; i < 5; i++) push(EV_MARK, 2 + 9 * i, 4);
        push(EV_DONE, 47, 0); push(EV_FALL, 48, 0);
        pulse(10'b01_01_01_01_01);
        drain("five_dots", 100);

        // empty pair after a played symbol ends the sequence
        push(EV_RISE, 1, 0); push(EV_MARK, 3, 12); push(EV_DONE, 20, 0); push(EV_FALL, 21, 0);
        pulse(10'b00_11_00_01_01);
        drain("early_end", 60);

        // 10 pair after a dot ends the sequence
        push(EV_RISE, 1, 0); push(EV_MARK, 2, 4); push(EV_DONE, 11, 0); push(EV_FALL, 12, 0);
        pulse(10'b01_10_11_11_11);
        drain("bad_pair", 40);

        // stop mid-mark, then start held off while stop is still high in IDLE
        push(EV_RISE, 1, 0); push(EV_MARK, 5, 3); push(EV_FALL, 8, 0);
        pulse(10'b00_00_00_01_11);
        wait_rel(7);
        stop = 1'b1;
        wait_rel(8);
        code  = 10'b00_00_00_00_01;
        start = 1'b1;
        wait_rel(9);
        stop  = 1'b0;
        start = 1'b0;
        repeat (12) @(negedge clock);
        check("stop_busy_held_low", int'(busy), 0);
        check("stop_pending_events", exp_q.size(), 0);
        exp_q.delete();

        // start while busy is ignored
        push(EV_RISE, 1, 0); push(EV_MARK, 5, 4); push(EV_MARK, 14, 12);
        push(EV_DONE, 31, 0); push(EV_FALL, 32, 0);
        pulse(10'b00_00_00_01_11);
        wait_rel(10);
        code  = 10'b01_01_01_01_01;
        start = 1'b1;
        wait_rel(11);
        start = 1'b0;
        drain("start_busy", 100);

        // asynchronous reset mid-playback, then a single line
        push(EV_RISE, 1, 0); push(EV_MARK, 5, 4); push(EV_FALL, 10, 0);
        pulse(10'b00_00_00_01_11);
        wait_rel(9);
        @(posedge clock);
        #1 resetn = 1'b0;
        #1;
        check("async_reset_morse_out", int'(morse_out), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_done", int'(done), 0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        check("reset_pending_events", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clock);
        push(EV_RISE, 1, 0); push(EV_MARK, 6, 12); push(EV_DONE, 23, 0); push(EV_FALL, 24, 0);
        pulse(10'b00_00_00_00_11);
        drain("after_reset", 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
